// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - fetch/load/store request unit with watchdog, sticky halt/error and perf counters
module mem_request_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_rd_i,
  input  logic             mem_wr_i,
  input  logic             halt_i,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             pc_en_o,
  output logic             halt_o,
  output logic             err_o,
  output logic [CNT_W-1:0] ifetch_cnt,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DREQ, HALT, ERROR} state_t;

  state_t           state_q, state_d;
  logic             dren_q, dren_d;
  logic             dwen_q, dwen_d;
  logic             halt_q, halt_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] ifetch_q, ifetch_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] store_q, store_d;
  logic             iren;
  logic             pc_en;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // State register and all registered outputs; reset clears everything immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      ifetch_q <= '0;
      load_q   <= '0;
      store_q  <= '0;
    end else begin
      state_q  <= state_d;
      dren_q   <= dren_d;
      dwen_q   <= dwen_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      ifetch_q <= ifetch_d;
      load_q   <= load_d;
      store_q  <= store_d;
    end
  end

  // Next-state, request enables, watchdog, counters and combinational iREN/pc_en.
  always_comb begin
    state_d  = state_q;
    dren_d   = dren_q;
    dwen_d   = dwen_q;
    halt_d   = halt_q;
    err_d    = err_q;
    wd_d     = wd_q;
    ifetch_d = ifetch_q;
    load_d   = load_q;
    store_d  = store_q;
    iren     = 1'b0;
    pc_en    = 1'b0;

    case (state_q)
      IDLE: begin
        iren = 1'b1;
        wd_d = '0;
        if (ihit) begin
          ifetch_d = sat_inc(ifetch_q);
          if (halt_i) begin
            // Halt takes priority; any decoded memory op is discarded.
            state_d = HALT;
            halt_d  = 1'b1;
          end else if (mem_wr_i) begin
            // A store wins when both read and write are decoded.
            state_d = DREQ;
            dwen_d  = 1'b1;
            dren_d  = 1'b0;
          end else if (mem_rd_i) begin
            state_d = DREQ;
            dren_d  = 1'b1;
            dwen_d  = 1'b0;
          end else begin
            pc_en = 1'b1;
          end
        end
      end

      DREQ: begin
        if (dhit) begin
          // Service on the expiry cycle still counts as success.
          state_d = IDLE;
          pc_en   = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          wd_d    = '0;
          if (dwen_q) store_d = sat_inc(store_q);
          else        load_d  = sat_inc(load_q);
        end else if (wd_q == WD_LAST) begin
          state_d = ERROR;
          err_d   = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      HALT: begin
        dren_d = 1'b0;
        dwen_d = 1'b0;
      end

      default: begin
        dren_d = 1'b0;
        dwen_d = 1'b0;
      end
    endcase
  end

  assign iREN       = iren;
  assign pc_en_o    = pc_en;
  assign dREN       = dren_q;
  assign dWEN       = dwen_q;
  assign halt_o     = halt_q;
  assign err_o      = err_q;
  assign ifetch_cnt = ifetch_q;
  assign load_cnt   = load_q;
  assign store_cnt  = store_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - directed self-checking bench for mem_request_unit
module tb_mem_request_unit;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_rd_i, mem_wr_i, halt_i;
  logic             iREN, dREN, dWEN, pc_en_o, halt_o, err_o;
  logic [CNT_W-1:0] ifetch_cnt, load_cnt, store_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int dren_cycles;

  mem_request_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .ihit      (ihit),
    .dhit      (dhit),
    .mem_rd_i  (mem_rd_i),
    .mem_wr_i  (mem_wr_i),
    .halt_i    (halt_i),
    .iREN      (iREN),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .pc_en_o   (pc_en_o),
    .halt_o    (halt_o),
    .err_o     (err_o),
    .ifetch_cnt(ifetch_cnt),
    .load_cnt  (load_cnt),
    .store_cnt (store_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle (called just after a rising edge), then wait to mid-cycle.
  task automatic drive(input logic ih, input logic dh, input logic rd, input logic wr, input logic hl);
    ihit = ih; dhit = dh; mem_rd_i = rd; mem_wr_i = wr; halt_i = hl;
    @(negedge CLK);
  endtask

  task automatic next_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_counts(input string tag, input int f, input int l, input int s);
    check_eq({tag, "_ifetch"}, 32'(ifetch_cnt), 32'(f));
    check_eq({tag, "_load"},   32'(load_cnt),   32'(l));
    check_eq({tag, "_store"},  32'(store_cnt),  32'(s));
  endtask

  initial begin
    nRST = 1'b0;
    ihit = 0; dhit = 0; mem_rd_i = 0; mem_wr_i = 0; halt_i = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_iren", 32'(iREN), 1);
    check_eq("rst_dren", 32'(dREN), 0);
    check_eq("rst_dwen", 32'(dWEN), 0);
    check_eq("rst_halt", 32'(halt_o), 0);
    check_eq("rst_err",  32'(err_o), 0);
    check_counts("rst", 0, 0, 0);
    nRST = 1'b1;

    // Plain fetches advance the PC each time.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      check_eq("t1_pc_en", 32'(pc_en_o), 1);
      next_edge();
      check_eq("t1_dren", 32'(dREN), 0);
      check_eq("t1_dwen", 32'(dWEN), 0);
    end
    check_counts("t1", 3, 0, 0);

    // Load serviced four cycles after the decode.
    drive(1, 0, 1, 0, 0);
    check_eq("t2_pc_en_dec", 32'(pc_en_o), 0);
    next_edge();
    dren_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 3) ? 1'b1 : 1'b0, 0, 0, 0);
      if (dREN) dren_cycles++;
      check_eq("t2_iren", 32'(iREN), 0);
      check_eq("t2_pc_en", 32'(pc_en_o), (i == 3) ? 1 : 0);
      next_edge();
    end
    check_eq("t2_dren_cycles", 32'(dren_cycles), 4);
    check_eq("t2_dren_after", 32'(dREN), 0);
    check_counts("t2", 4, 1, 0);

    // Read and write both decoded: the store wins.
    drive(1, 0, 1, 1, 0);
    next_edge();
    check_eq("t3_dwen", 32'(dWEN), 1);
    check_eq("t3_dren", 32'(dREN), 0);
    drive(0, 1, 0, 0, 0);
    check_eq("t3_pc_en", 32'(pc_en_o), 1);
    next_edge();
    check_eq("t3_dwen_after", 32'(dWEN), 0);
    check_counts("t3", 5, 1, 1);

    // dhit on the watchdog-expiry cycle still completes the store.
    drive(1, 0, 0, 1, 0);
    next_edge();
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 3) ? 1'b1 : 1'b0, 0, 0, 0);
      next_edge();
    end
    check_eq("t4b_err", 32'(err_o), 0);
    check_eq("t4b_iren", 32'(iREN), 1);
    check_counts("t4b", 6, 1, 2);

    // dhit while idle is ignored.
    drive(0, 1, 0, 0, 0);
    check_eq("idle_dhit_pc_en", 32'(pc_en_o), 0);
    next_edge();
    check_counts("idle_dhit", 6, 1, 2);

    // Fetch counter saturates at 7 with a 3-bit width.
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      next_edge();
    end
    check_counts("sat", 7, 1, 2);

    // Store with no dhit: error after four waiting cycles.
    drive(1, 0, 0, 1, 0);
    next_edge();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      check_eq("t4a_dwen_wait", 32'(dWEN), 1);
      check_eq("t4a_err_wait", 32'(err_o), 0);
      next_edge();
    end
    check_eq("t4a_err", 32'(err_o), 1);
    check_eq("t4a_dwen", 32'(dWEN), 0);
    drive(1, 1, 1, 0, 0);
    check_eq("t4a_iren", 32'(iREN), 0);
    check_eq("t4a_pc_en", 32'(pc_en_o), 0);
    next_edge();
    check_eq("t4a_err_sticky", 32'(err_o), 1);
    check_counts("t4a", 7, 1, 2);

    // Reset clears the error; then reset mid-load drops dREN at once.
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    next_edge();
    check_eq("rst2_err", 32'(err_o), 0);
    drive(1, 0, 1, 0, 0);
    next_edge();
    check_eq("t6_dren_pre", 32'(dREN), 1);
    drive(0, 0, 0, 0, 0);
    nRST = 1'b0;
    #1;
    check_eq("t6_dren", 32'(dREN), 0);
    check_eq("t6_iren", 32'(iREN), 1);
    check_counts("t6", 0, 0, 0);
    next_edge();
    nRST = 1'b1;

    // Halt beats a decoded load and is sticky.
    drive(1, 0, 1, 0, 1);
    check_eq("t5_pc_en", 32'(pc_en_o), 0);
    next_edge();
    check_eq("t5_halt", 32'(halt_o), 1);
    check_eq("t5_dren", 32'(dREN), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0);
      check_eq("t5_iren", 32'(iREN), 0);
      check_eq("t5_pc_en_later", 32'(pc_en_o), 0);
      next_edge();
      check_eq("t5_dren_later", 32'(dREN), 0);
    end
    check_eq("t5_halt_sticky", 32'(halt_o), 1);
    check_counts("t5", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
